multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control unit for the multi-cycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type and beq.
- Produces the 2-bit aluop consumed by alu_control, plus every datapath mux select and write strobe.
- Waits on a memory ready handshake during fetch and data access.

Parameters:
- None. All encodings are fixed constants in riscv_pkg.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  7  instr[6:0] from the instruction register (valid from DECODE onward)
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- aluop  output  2  00=ADD, 01=SUB, 10=funct decode
- alu_src_a  output  2  00=PC, 01=rs1 reg, 10=oldPC
- alu_src_b  output  2  00=rs2 reg, 01=constant 4, 10=immediate
- pc_src  output  1  0=ALU result, 1=ALUOut register
- pc_en  output  1  PC register write enable
- ir_write  output  1  instruction register load
- iord  output  1  0=address from PC, 1=address from ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- reg_write  output  1  register file write
- mem_to_reg  output  1  writeback source: 0=ALUOut, 1=memory data register
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- illegal  output  1  sticky; set on an unsupported opcode
- state_dbg  output  4  current state encoding

Behaviour:
- Clock and reset: single clk domain. rst is synchronous and active-high.
- Reset entry: with rst=1 at a rising edge, next state is FETCH and illegal clears.
- Reset outputs: while rst=1, every strobe (pc_en, ir_write, mem_read, mem_write, reg_write, instr_done) is 0 and aluop=00. Selects take their FETCH values.
- Reset mid-access: a reset during any state, including a pending memory wait, abandons the instruction with no writes.
- Output style: Moore decode of the state register, except pc_en, ir_write and instr_done, which also depend on mem_ready or zero.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, aluop=00, pc_src=0.
  - ir_write and pc_en are asserted only in the cycle where mem_ready=1.
  - Next state: stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=10, alu_src_b=10, aluop=00 (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 → MEM_ADDR; 0110011 → EXECUTE; 1100011 → BRANCH; any other → HALT.
- MEM_ADDR:
  - Outputs: alu_src_a=01, alu_src_b=10, aluop=00.
  - Next state: MEM_READ if opcode=0000011, else MEM_WRITE.
- MEM_READ:
  - Outputs: mem_read=1, iord=1.
  - Next state: hold until mem_ready=1, then MEM_WB.
- MEM_WB:
  - Outputs: reg_write=1, mem_to_reg=1, instr_done=1.
  - Next state: FETCH.
- MEM_WRITE:
  - Outputs: mem_write=1, iord=1.
  - instr_done is asserted in the cycle where mem_ready=1.
  - Next state: FETCH on mem_ready=1.
- EXECUTE:
  - Outputs: alu_src_a=01, alu_src_b=00, aluop=10.
  - Next state: ALU_WB.
- ALU_WB:
  - Outputs: reg_write=1, mem_to_reg=0, instr_done=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: alu_src_a=01, alu_src_b=00, aluop=01, pc_src=1, instr_done=1.
  - pc_en = zero.
  - Next state: FETCH.
- HALT:
  - Outputs: illegal=1, all strobes 0.
  - Next state: stays in HALT until rst.
- Zero-wait latencies (mem_ready tied high): lw 5 cycles, sw 4, R-type 4, beq 3.
- Mutual exclusion: mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.
- Timing of mem_ready: mem_ready=1 in a state with no memory request is ignored.
- Multi-cycle accesses: a request is held stable, with unchanged iord, until mem_ready is seen.

Decomposition:
- riscv_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH);
  - aluop constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - alu_src_a and alu_src_b select constants;
  - the ctrl_state_t enum, 4-bit, with FETCH=0.
- No sub-module: one state register, a next-state block and an output decode block.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with mem_ready=1 → all strobes 0 and state_dbg=FETCH. First cycle after release: mem_read=1, ir_write=1, pc_en=1.
2. R-type, mem_ready=1, opcode=0110011 → states FETCH, DECODE, EXECUTE, ALU_WB. aluop=10 in EXECUTE. reg_write=1 with mem_to_reg=0 on cycle 4, and instr_done pulses once.
3. lw with 2 wait cycles on both fetch and data, opcode=0000011:
   - FETCH lasts 3 cycles and ir_write fires only on the third;
   - MEM_READ lasts 3 cycles with iord=1;
   - then MEM_WB with mem_to_reg=1.
   - Total 9 cycles.
4. beq, opcode=1100011: with zero=1 → pc_en=1, pc_src=1, aluop=01 in cycle 3. Repeat with zero=0 → pc_en=0.
5. sw, opcode=0100011, mem_ready=1 → mem_write=1 in cycle 4, reg_write is never 1, and instr_done=1 in cycle 4.
6. Illegal opcode 1111111 → HALT after DECODE. illegal=1 and all strobes stay 0 for 10 cycles. Asserting rst clears illegal and returns to FETCH.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared encodings for the multi-cycle RV32I datapath control:
//   - opcode constants for the supported instruction classes
//   - aluop codes handed to alu_control
//   - alu_src_a / alu_src_b mux select codes
//   - ctrl_state_t, the 4-bit main control state encoding (FETCH = 0)
// ---------------------------------------------------------------------------
package riscv_pkg;

    // Opcodes (instr[6:0]) the control unit knows how to sequence
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // aluop: what alu_control should make the ALU do
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand A sources
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    // ALU operand B sources
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // Main control states; the numeric values are visible on state_dbg
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        HALT      = 4'd9
    } ctrl_state_t;

endpackage

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Main control unit of the multi-cycle RV32I datapath. Sequences fetch,
// decode, execute, memory access and writeback for lw, sw, R-type and beq,
// stalling on mem_ready during instruction fetch and data access.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   opcode[6:0]      instr[6:0] from the instruction register
//   zero             ALU zero flag (branch decision)
//   mem_ready        memory completes the current access this cycle
//   aluop[1:0]       00=ADD, 01=SUB, 10=funct decode
//   alu_src_a[1:0]   00=PC, 01=rs1, 10=oldPC
//   alu_src_b[1:0]   00=rs2, 01=constant 4, 10=immediate
//   pc_src           0=ALU result, 1=ALUOut register
//   pc_en, ir_write  PC / instruction register write enables
//   iord             memory address: 0=PC, 1=ALUOut
//   mem_read/write   memory request strobes
//   reg_write        register file write
//   mem_to_reg       writeback source: 0=ALUOut, 1=memory data register
//   instr_done       pulse on the last cycle of each instruction
//   illegal          sticky unsupported-opcode flag
//   state_dbg[3:0]   current state encoding
// ---------------------------------------------------------------------------
module multicycle_control_fsm
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] aluop,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_src,
    output logic       pc_en,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic        illegal_q;

    // State register plus the sticky illegal flag. The flag is set on the
    // transition into HALT so it is already high for the first HALT cycle,
    // and only a reset can clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == HALT) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state logic. Memory states hold until mem_ready; states with no
    // memory request ignore mem_ready entirely.
    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  next_state = MEM_ADDR;
                    OP_RTYPE:  next_state = EXECUTE;
                    OP_BRANCH: next_state = BRANCH;
                    default:   next_state = HALT;
                endcase
            end
            MEM_ADDR: begin
                next_state = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                if (mem_ready) next_state = MEM_WB;
            end
            MEM_WB:    next_state = FETCH;
            MEM_WRITE: begin
                if (mem_ready) next_state = FETCH;
            end
            EXECUTE:   next_state = ALU_WB;
            ALU_WB:    next_state = FETCH;
            BRANCH:    next_state = FETCH;
            HALT:      next_state = HALT;
            // Unused encodings are treated as a fault and parked in HALT
            default:   next_state = HALT;
        endcase
    end

    // Output decode. Mostly Moore on the state register; pc_en, ir_write and
    // instr_done additionally look at mem_ready / zero so the write lands in
    // the same cycle the access completes. While rst is high every strobe is
    // forced low and the selects show their FETCH values, so an abandoned
    // instruction can never write anything.
    always_comb begin
        aluop      = ALUOP_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        pc_src     = 1'b0;
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        if (rst) begin
            alu_src_b = SRCB_FOUR;
        end else begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                MEM_ADDR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                EXECUTE: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    aluop     = ALUOP_FUNCT;
                end
                ALU_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    aluop      = ALUOP_SUB;
                    pc_src     = 1'b1;
                    pc_en      = zero;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign illegal   = illegal_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Directed bench for the multi-cycle control FSM. Each step drives one
// cycle of inputs together with the state the FSM is expected to be in,
// pushes the full expected output vector onto a scoreboard queue and pops
// it against the DUT outputs shortly after.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_ALU_WB    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_HALT      = 4'd9;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct packed {
        logic [3:0] state;
        logic [1:0] aluop;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       pc_src;
        logic       pc_en;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal;
    } out_t;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] aluop;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_src;
    logic       pc_en;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state_dbg;

    int   tests_run    = 0;
    int   tests_failed = 0;
    out_t exp_q[$];

    multicycle_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .aluop      (aluop),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference output table: what each state must present, given the
    // current inputs, as listed in the control unit's behaviour table.
    function automatic out_t refOut(input logic [3:0] st, input logic r,
                                    input logic mr, input logic z);
        out_t o;
        o         = '0;
        o.state   = st;
        o.illegal = (st == S_HALT);
        if (r) begin
            o.src_b = 2'b01;
            return o;
        end
        case (st)
            S_FETCH: begin
                o.mem_read = 1'b1;
                o.src_b    = 2'b01;
                o.ir_write = mr;
                o.pc_en    = mr;
            end
            S_DECODE: begin
                o.src_a = 2'b10;
                o.src_b = 2'b10;
            end
            S_MEM_ADDR: begin
                o.src_a = 2'b01;
                o.src_b = 2'b10;
            end
            S_MEM_READ: begin
                o.mem_read = 1'b1;
                o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = 1'b1;
                o.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                o.mem_write  = 1'b1;
                o.iord       = 1'b1;
                o.instr_done = mr;
            end
            S_EXECUTE: begin
                o.src_a = 2'b01;
                o.aluop = 2'b10;
            end
            S_ALU_WB: begin
                o.reg_write  = 1'b1;
                o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                o.src_a      = 2'b01;
                o.aluop      = 2'b01;
                o.pc_src     = 1'b1;
                o.pc_en      = z;
                o.instr_done = 1'b1;
            end
            default: begin
            end
        endcase
        return o;
    endfunction

    // Pop the oldest expectation and compare it with what the DUT shows now
    task automatic checkOutput(input string tag);
        out_t obs;
        out_t exp;
        obs = '{state_dbg, aluop, alu_src_a, alu_src_b, pc_src, pc_en,
                ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
                instr_done, illegal};
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $error("[TB] FAIL %s: scoreboard empty, observed=%h", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        tests_run++;
        assert ((obs.mem_read & obs.mem_write) === 1'b0 &&
                (obs.reg_write & obs.mem_write) === 1'b0) else begin
            tests_failed++;
            $error("[TB] FAIL %s_excl: observed rd/wr/rw=%b%b%b expected no overlap",
                   tag, obs.mem_read, obs.mem_write, obs.reg_write);
        end
    endtask

    // One cycle: drive inputs on the falling edge, queue the expectation,
    // check it 1 ns later (well clear of the next rising edge).
    task automatic applyStimulus(input string tag, input logic r,
                                 input logic [6:0] op, input logic z,
                                 input logic mr, input logic [3:0] st);
        @(negedge clk);
        rst       = r;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back(refOut(st, r, mr, z));
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 7'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);

        // Reset held three cycles with mem_ready high, then first fetch
        applyStimulus("rst0", 1'b1, 7'd0, 1'b0, 1'b1, S_FETCH);
        applyStimulus("rst1", 1'b1, 7'd0, 1'b0, 1'b1, S_FETCH);
        applyStimulus("rst2", 1'b1, 7'd0, 1'b0, 1'b1, S_FETCH);
        applyStimulus("rt_fetch", 1'b0, RT, 1'b0, 1'b1, S_FETCH);

        // R-type, zero wait
        applyStimulus("rt_decode", 1'b0, RT, 1'b0, 1'b1, S_DECODE);
        applyStimulus("rt_exec",   1'b0, RT, 1'b0, 1'b1, S_EXECUTE);
        applyStimulus("rt_wb",     1'b0, RT, 1'b0, 1'b1, S_ALU_WB);

        // lw with two wait cycles on fetch and on data
        applyStimulus("lw_fetch0", 1'b0, LW, 1'b0, 1'b0, S_FETCH);
        applyStimulus("lw_fetch1", 1'b0, LW, 1'b0, 1'b0, S_FETCH);
        applyStimulus("lw_fetch2", 1'b0, LW, 1'b0, 1'b1, S_FETCH);
        applyStimulus("lw_decode", 1'b0, LW, 1'b0, 1'b1, S_DECODE);
        applyStimulus("lw_addr",   1'b0, LW, 1'b0, 1'b0, S_MEM_ADDR);
        applyStimulus("lw_read0",  1'b0, LW, 1'b0, 1'b0, S_MEM_READ);
        applyStimulus("lw_read1",  1'b0, LW, 1'b0, 1'b0, S_MEM_READ);
        applyStimulus("lw_read2",  1'b0, LW, 1'b0, 1'b1, S_MEM_READ);
        applyStimulus("lw_wb",     1'b0, LW, 1'b0, 1'b0, S_MEM_WB);

        // beq taken
        applyStimulus("beq1_fetch",  1'b0, BEQ, 1'b1, 1'b1, S_FETCH);
        applyStimulus("beq1_decode", 1'b0, BEQ, 1'b1, 1'b1, S_DECODE);
        applyStimulus("beq1_branch", 1'b0, BEQ, 1'b1, 1'b1, S_BRANCH);

        // beq not taken
        applyStimulus("beq0_fetch",  1'b0, BEQ, 1'b0, 1'b1, S_FETCH);
        applyStimulus("beq0_decode", 1'b0, BEQ, 1'b0, 1'b1, S_DECODE);
        applyStimulus("beq0_branch", 1'b0, BEQ, 1'b0, 1'b1, S_BRANCH);

        // sw, zero wait
        applyStimulus("sw_fetch",  1'b0, SW, 1'b0, 1'b1, S_FETCH);
        applyStimulus("sw_decode", 1'b0, SW, 1'b0, 1'b1, S_DECODE);
        applyStimulus("sw_addr",   1'b0, SW, 1'b0, 1'b1, S_MEM_ADDR);
        applyStimulus("sw_write",  1'b0, SW, 1'b0, 1'b1, S_MEM_WRITE);

        // sw with one data wait: request held, done only on ready
        applyStimulus("sww_fetch",  1'b0, SW, 1'b0, 1'b1, S_FETCH);
        applyStimulus("sww_decode", 1'b0, SW, 1'b0, 1'b0, S_DECODE);
        applyStimulus("sww_addr",   1'b0, SW, 1'b0, 1'b0, S_MEM_ADDR);
        applyStimulus("sww_write0", 1'b0, SW, 1'b0, 1'b0, S_MEM_WRITE);
        applyStimulus("sww_write1", 1'b0, SW, 1'b0, 1'b1, S_MEM_WRITE);

        // Reset during a pending lw data wait abandons it without writes
        applyStimulus("ab_fetch",  1'b0, LW, 1'b0, 1'b1, S_FETCH);
        applyStimulus("ab_decode", 1'b0, LW, 1'b0, 1'b1, S_DECODE);
        applyStimulus("ab_addr",   1'b0, LW, 1'b0, 1'b1, S_MEM_ADDR);
        applyStimulus("ab_read0",  1'b0, LW, 1'b0, 1'b0, S_MEM_READ);
        applyStimulus("ab_rst",    1'b1, LW, 1'b0, 1'b1, S_MEM_READ);
        applyStimulus("ab_fetch2", 1'b0, LW, 1'b0, 1'b0, S_FETCH);
        applyStimulus("ab_fetch3", 1'b0, LW, 1'b0, 1'b1, S_FETCH);

        // Illegal opcode parks in HALT until reset
        applyStimulus("il_decode", 1'b0, BAD, 1'b1, 1'b1, S_DECODE);
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("il_halt%0d", i), 1'b0, BAD, 1'b1, 1'b1, S_HALT);
        end
        applyStimulus("il_rst",   1'b1, BAD, 1'b0, 1'b1, S_HALT);
        applyStimulus("il_fetch", 1'b0, RT,  1'b0, 1'b1, S_FETCH);
        applyStimulus("il_decode2", 1'b0, RT, 1'b0, 1'b1, S_DECODE);

        tests_run++;
        assert (exp_q.size() == 0) else begin
            tests_failed++;
            $error("[TB] FAIL sb_drain: observed=%0d entries left expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
